// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter: FSM states,
// line geometry, grant encoding and the wrapping word-index helper.
package sdram_arb_pkg;

    localparam int BURST_LEN = 8;
    localparam int WIDX_W    = 3;

    localparam logic GRANT_FILL = 1'b0;
    localparam logic GRANT_WR   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_FILL_CMD     = 3'd1,
        ST_FILL_COLLECT = 3'd2,
        ST_FILL_REPLAY  = 3'd3,
        ST_WR_CMD       = 3'd4
    } state_t;

    // Word index within a line; 3-bit addition wraps naturally at the line end.
    function automatic logic [WIDX_W-1:0] wrap_idx(input logic [WIDX_W-1:0] base,
                                                   input logic [WIDX_W-1:0] off);
        return base + off;
    endfunction

endpackage

// File: rtl/burst_line_buffer.sv
// 8x16 line buffer: one capture write port and one rotated replay read port.
// A read of the word being written this cycle returns the incoming data.
module burst_line_buffer
    import sdram_arb_pkg::*;
#(
    parameter int DATA_W = 16
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_we,
    input  logic [WIDX_W-1:0] i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [WIDX_W-1:0] i_rbase,
    input  logic [WIDX_W-1:0] i_roff,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [BURST_LEN];
    logic [WIDX_W-1:0] w_ridx;

    assign w_ridx = wrap_idx(i_rbase, i_roff);

    // Capture port
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < BURST_LEN; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    // Replay port with write-through so the last captured word can be replayed first
    always_comb begin
        if (i_we && (i_widx == w_ridx)) begin
            o_rdata = i_wdata;
        end else begin
            o_rdata = r_mem[w_ridx];
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM command port between cache line fills and CPU writes;
// fill words are buffered and replayed as a gap-free critical-word-first burst.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = 25
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fill_req,
    input  logic [ADDR_W-1:0] fill_addr,
    output logic              fill_strobe,
    output logic [15:0]       fill_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [1:0]        wr_be,
    output logic              wr_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_grant;
    logic [WIDX_W-1:0] r_cnt;
    logic [WIDX_W-1:0] r_k;
    logic [WIDX_W-1:0] r_start;

    logic              r_fill_strobe, w_fill_strobe_nxt;
    logic [15:0]       r_fill_data,   w_fill_data_nxt;
    logic              r_wr_ack,      w_wr_ack_nxt;
    logic              r_mem_req,     w_mem_req_nxt;
    logic              r_mem_we,      w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,    w_mem_addr_nxt;
    logic [1:0]        r_mem_be,      w_mem_be_nxt;
    logic [15:0]       r_mem_wdata,   w_mem_wdata_nxt;

    logic              w_grant_fill;
    logic              w_grant_wr;
    logic              w_ack_ok;
    logic              w_buf_we;
    logic              w_last_word;
    logic [WIDX_W-1:0] w_roff;
    logic [15:0]       w_buf_rdata;

    assign w_grant_fill = fill_req && (!wr_req || (r_last_grant == GRANT_WR));
    assign w_grant_wr   = wr_req && (!fill_req || (r_last_grant == GRANT_FILL));
    assign w_ack_ok     = mem_ack && r_mem_req;
    assign w_buf_we     = (r_state == ST_FILL_COLLECT) && mem_rvalid;
    assign w_last_word  = w_buf_we && (r_cnt == 3'd7);
    // Registered output leads the replay counter by one word
    assign w_roff       = (r_state == ST_FILL_REPLAY) ? (r_k + 3'd1) : 3'd0;

    burst_line_buffer #(.DATA_W(16)) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_buf_we),
        .i_widx  (r_cnt),
        .i_wdata (mem_rdata),
        .i_rbase (r_start),
        .i_roff  (w_roff),
        .o_rdata (w_buf_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_fill)    w_state_nxt = ST_FILL_CMD;
                else if (w_grant_wr) w_state_nxt = ST_WR_CMD;
                else                 w_state_nxt = ST_IDLE;
            end
            ST_FILL_CMD: begin
                if (w_ack_ok) w_state_nxt = ST_FILL_COLLECT;
                else          w_state_nxt = ST_FILL_CMD;
            end
            ST_FILL_COLLECT: begin
                if (w_last_word) w_state_nxt = ST_FILL_REPLAY;
                else             w_state_nxt = ST_FILL_COLLECT;
            end
            ST_FILL_REPLAY: begin
                if (r_k == 3'd7) w_state_nxt = ST_IDLE;
                else             w_state_nxt = ST_FILL_REPLAY;
            end
            ST_WR_CMD: begin
                if (w_ack_ok) w_state_nxt = ST_IDLE;
                else          w_state_nxt = ST_WR_CMD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output values for the next cycle; command fields hold while awaiting mem_ack
    always_comb begin
        w_fill_strobe_nxt = 1'b0;
        w_fill_data_nxt   = 16'h0000;
        w_wr_ack_nxt      = 1'b0;
        w_mem_req_nxt     = 1'b0;
        w_mem_we_nxt      = 1'b0;
        w_mem_addr_nxt    = {ADDR_W{1'b0}};
        w_mem_be_nxt      = 2'b11;
        w_mem_wdata_nxt   = 16'h0000;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_fill) begin
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = {fill_addr[ADDR_W-1:3], 3'b000};
                end else if (w_grant_wr) begin
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = wr_addr;
                    w_mem_be_nxt    = wr_be;
                    w_mem_wdata_nxt = wr_data;
                end else begin
                    w_mem_req_nxt = 1'b0;
                end
            end
            ST_FILL_CMD: begin
                if (!w_ack_ok) begin
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = r_mem_addr;
                end else begin
                    w_mem_req_nxt = 1'b0;
                end
            end
            ST_FILL_COLLECT: begin
                if (w_last_word) begin
                    w_fill_strobe_nxt = 1'b1;
                    w_fill_data_nxt   = w_buf_rdata;
                end else begin
                    w_fill_strobe_nxt = 1'b0;
                end
            end
            ST_FILL_REPLAY: begin
                if (r_k != 3'd7) begin
                    w_fill_data_nxt = w_buf_rdata;
                end else begin
                    w_fill_data_nxt = 16'h0000;
                end
            end
            ST_WR_CMD: begin
                if (w_ack_ok) begin
                    w_wr_ack_nxt = 1'b1;
                end else begin
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = r_mem_addr;
                    w_mem_be_nxt    = r_mem_be;
                    w_mem_wdata_nxt = r_mem_wdata;
                end
            end
            default: w_mem_req_nxt = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fill_strobe <= 1'b0;
            r_fill_data   <= 16'h0000;
            r_wr_ack      <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= {ADDR_W{1'b0}};
            r_mem_be      <= 2'b11;
            r_mem_wdata   <= 16'h0000;
        end else begin
            r_fill_strobe <= w_fill_strobe_nxt;
            r_fill_data   <= w_fill_data_nxt;
            r_wr_ack      <= w_wr_ack_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_be      <= w_mem_be_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
        end
    end

    // Capture/replay counters, critical-word index and fairness history
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt        <= 3'd0;
            r_k          <= 3'd0;
            r_start      <= 3'd0;
            r_last_grant <= GRANT_FILL;
        end else begin
            if ((r_state == ST_IDLE) && w_grant_fill) r_start <= fill_addr[2:0];
            if ((r_state == ST_FILL_CMD) && w_ack_ok)  r_cnt <= 3'd0;
            else if (w_buf_we)                         r_cnt <= r_cnt + 3'd1;
            if (w_last_word)                           r_k <= 3'd0;
            else if (r_state == ST_FILL_REPLAY)        r_k <= r_k + 3'd1;
            if ((r_state == ST_FILL_REPLAY) && (r_k == 3'd7)) r_last_grant <= GRANT_FILL;
            else if ((r_state == ST_WR_CMD) && w_ack_ok)      r_last_grant <= GRANT_WR;
        end
    end

    assign fill_strobe = r_fill_strobe;
    assign fill_data   = r_fill_data;
    assign wr_ack      = r_wr_ack;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_be      = r_mem_be;
    assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed + randomized bench for sdram_port_arbiter; the bench plays both the
// cache/CPU requesters and the SDRAM controller, predicting every output.
module tb_sdram_port_arbiter;

    typedef logic [15:0] line_t [8];
    typedef int          gap_t  [8];

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fill_req;
    logic [24:0] fill_addr;
    logic        fill_strobe;
    logic [15:0] fill_data;
    logic        wr_req;
    logic [24:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        wr_ack;
    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    int passed = 0;
    int total  = 0;
    int failed = 0;
    int m_last = 0;   // requester served most recently: 0 fill, 1 write

    always #5 clk = ~clk;

    sdram_port_arbiter #(.ADDR_W(25)) dut (
        .clk(clk), .reset_n(reset_n),
        .fill_req(fill_req), .fill_addr(fill_addr),
        .fill_strobe(fill_strobe), .fill_data(fill_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_ack(wr_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req"},    {31'd0, mem_req},     32'd0);
        chk({tag, "_strobe"}, {31'd0, fill_strobe}, 32'd0);
        chk({tag, "_data"},   {16'd0, fill_data},   32'd0);
        chk({tag, "_wrack"},  {31'd0, wr_ack},      32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; fill_req = 1'b0; wr_req = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0000;
        repeat (3) step();
        chk("rst_req",   {31'd0, mem_req},     32'd0);
        chk("rst_we",    {31'd0, mem_we},      32'd0);
        chk("rst_addr",  {7'd0, mem_addr},     32'd0);
        chk("rst_be",    {30'd0, mem_be},      32'd3);
        chk("rst_wdata", {16'd0, mem_wdata},   32'd0);
        chk("rst_strb",  {31'd0, fill_strobe}, 32'd0);
        chk("rst_fdata", {16'd0, fill_data},   32'd0);
        chk("rst_wrack", {31'd0, wr_ack},      32'd0);
        reset_n = 1'b1;
        m_last = 0;
        step();
    endtask

    // Entered one cycle after the grant edge; returns in the first IDLE cycle.
    task automatic serve_fill(input logic [24:0] addr, input line_t words,
                              input gap_t gaps, input int ack_dly);
        int s;
        s = int'(addr[2:0]);
        chk("fill_wrack_low", {31'd0, wr_ack},  32'd0);
        chk("fill_cmd_req",   {31'd0, mem_req}, 32'd1);
        chk("fill_cmd_we",    {31'd0, mem_we},  32'd0);
        chk("fill_cmd_addr",  {7'd0, mem_addr}, {7'd0, addr[24:3], 3'b000});
        chk("fill_cmd_be",    {30'd0, mem_be},  32'd3);
        repeat (ack_dly) begin
            step();
            chk("fill_cmd_hold", {31'd0, mem_req}, 32'd1);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("fill_cmd_drop", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (gaps[i]) begin
                mem_rvalid = 1'b0;
                step();
                chk("fill_early_strobe", {31'd0, fill_strobe}, 32'd0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = words[i];
            step();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 16'(($urandom));
        chk("replay_strobe", {31'd0, fill_strobe}, 32'd1);
        chk("replay_w0",     {16'd0, fill_data},   {16'd0, words[s]});
        fill_req = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            chk("replay_strobe_low", {31'd0, fill_strobe}, 32'd0);
            chk("replay_word",       {16'd0, fill_data},   {16'd0, words[(s + i) % 8]});
        end
        step();
        chk("replay_end_strobe", {31'd0, fill_strobe}, 32'd0);
        chk("replay_end_data",   {16'd0, fill_data},   32'd0);
        chk("replay_end_req",    {31'd0, mem_req},     32'd0);
        m_last = 0;
    endtask

    task automatic serve_wr(input logic [24:0] addr, input logic [15:0] data,
                            input logic [1:0] be, input int ack_dly);
        chk("wr_wrack_low", {31'd0, wr_ack},   32'd0);
        chk("wr_cmd_req",   {31'd0, mem_req},  32'd1);
        chk("wr_cmd_we",    {31'd0, mem_we},   32'd1);
        chk("wr_cmd_addr",  {7'd0, mem_addr},  {7'd0, addr});
        chk("wr_cmd_be",    {30'd0, mem_be},   {30'd0, be});
        chk("wr_cmd_wdata", {16'd0, mem_wdata},{16'd0, data});
        repeat (ack_dly) begin
            step();
            chk("wr_cmd_hold", {31'd0, mem_req}, 32'd1);
            chk("wr_ack_early",{31'd0, wr_ack},  32'd0);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("wr_ack_pulse", {31'd0, wr_ack},  32'd1);
        chk("wr_cmd_drop",  {31'd0, mem_req}, 32'd0);
        wr_req = 1'b0;
        m_last = 1;
    endtask

    initial begin
        line_t w;
        gap_t  g;
        logic [24:0] fa, wa;
        logic [15:0] wd;
        logic [1:0]  wb;
        int kind;

        fill_addr = 25'd0; wr_addr = 25'd0; wr_data = 16'h0000; wr_be = 2'b00;
        do_reset();

        // Fill only, start word 3, two-cycle gap before word 3
        for (int i = 0; i < 8; i++) begin w[i] = 16'hA0 + 16'(i); g[i] = 0; end
        g[3] = 2;
        fill_addr = 25'h000013; fill_req = 1'b1;
        step();
        serve_fill(25'h000013, w, g, 1);

        // Write only
        wr_addr = 25'h0001FF; wr_data = 16'hBEEF; wr_be = 2'b01; wr_req = 1'b1;
        step();
        serve_wr(25'h0001FF, 16'hBEEF, 2'b01, 2);

        // Simultaneous requests from reset: write first, then fill, twice
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 8; i++) begin w[i] = 16'(($urandom)); g[i] = p; end
            fill_addr = 25'h000A45 + 25'(p); fill_req = 1'b1;
            wr_addr = 25'h1234567 + 25'(p); wr_data = 16'h5A00 + 16'(p); wr_be = 2'b10; wr_req = 1'b1;
            step();
            serve_wr(25'h1234567 + 25'(p), 16'h5A00 + 16'(p), 2'b10, p);
            step();
            serve_fill(25'h000A45 + 25'(p), w, g, 0);
        end

        // Critical word is the last word of the line
        for (int i = 0; i < 8; i++) begin w[i] = 16'(($urandom)); g[i] = int'($urandom_range(0, 2)); end
        fill_addr = 25'h0ABCDF; fill_req = 1'b1;
        step();
        serve_fill(25'h0ABCDF, w, g, 3);

        // Reset while a fill command is outstanding
        fill_addr = 25'h000100; fill_req = 1'b1;
        step();
        chk("rst_cmd_pre_req", {31'd0, mem_req}, 32'd1);
        reset_n = 1'b0; fill_req = 1'b0;
        step();
        chk("rst_cmd_req", {31'd0, mem_req}, 32'd0);
        chk("rst_cmd_addr",{7'd0, mem_addr}, 32'd0);
        reset_n = 1'b1;
        step();

        // Reset after four collected words; late read data must be ignored
        fill_addr = 25'h000208; fill_req = 1'b1;
        step();
        chk("rst_col_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin mem_rvalid = 1'b1; mem_rdata = 16'hC0 + 16'(i); step(); end
        mem_rvalid = 1'b0; reset_n = 1'b0; fill_req = 1'b0;
        step();
        chk("rst_col_be",  {30'd0, mem_be}, 32'd3);
        chk_quiet("rst_col");
        reset_n = 1'b1; m_last = 0;
        for (int i = 0; i < 6; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 16'hC4 + 16'(i);
            step();
            chk_quiet("late_rvalid");
        end
        mem_rvalid = 1'b0;

        // Stray controller pulses while idle
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_ack = 1'b1; mem_rdata = 16'(($urandom));
            step();
            chk_quiet("stray");
            chk("stray_be", {30'd0, mem_be}, 32'd3);
        end
        mem_rvalid = 1'b0; mem_ack = 1'b0;
        step();

        // Randomized traffic against the arbitration/replay model
        for (int it = 0; it < 30; it++) begin
            kind = int'($urandom_range(0, 2));
            fa = 25'(($urandom)); wa = 25'(($urandom));
            wd = 16'(($urandom)); wb = 2'(($urandom));
            for (int i = 0; i < 8; i++) begin w[i] = 16'(($urandom)); g[i] = int'($urandom_range(0, 2)); end
            fill_addr = fa; wr_addr = wa; wr_data = wd; wr_be = wb;
            fill_req = (kind != 1); wr_req = (kind != 0);
            step();
            if (kind == 0) begin
                serve_fill(fa, w, g, int'($urandom_range(0, 3)));
            end else if (kind == 1) begin
                serve_wr(wa, wd, wb, int'($urandom_range(0, 3)));
            end else if (m_last == 0) begin
                serve_wr(wa, wd, wb, int'($urandom_range(0, 3)));
                step();
                serve_fill(fa, w, g, int'($urandom_range(0, 3)));
            end else begin
                serve_fill(fa, w, g, int'($urandom_range(0, 3)));
                step();
                serve_wr(wa, wd, wb, int'($urandom_range(0, 3)));
            end
            repeat (int'($urandom_range(0, 2))) begin
                mem_rvalid = 1'($urandom); mem_ack = 1'($urandom);
                step();
                chk_quiet("rand_idle");
            end
            mem_rvalid = 1'b0; mem_ack = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
